aes_block_collector: RTL

Parametrised successor to the 32-bit AES text/key input buffer. Gathers BUS_W-wide beats of plaintext and key into a TEXT_W text block and a KEY_W key block, supporting 128/192/256-bit keys. Issues a one-cycle load pulse to the AES core and holds both blocks stable until the core signals done. Sits between the host bus interface and the AES round core.

---
 rtl/aes_buf_pkg.sv | 24 ++
 rtl/aes_block_collector_if.sv | 37 +++
 rtl/aes_word_packer.sv | 33 +++
 rtl/aes_block_collector.sv | 132 +++++++++++++
 4 files changed

// File: rtl/aes_buf_pkg.sv
// Shared types and helpers for the AES text/key block collector.
// FSM state encoding, legal key widths and elaboration-time width arithmetic.
package aes_buf_pkg;

  typedef logic [1:0] aes_state_t;

  localparam aes_state_t S_IDLE = 2'd0;
  localparam aes_state_t S_FILL = 2'd1;
  localparam aes_state_t S_LOAD = 2'd2;
  localparam aes_state_t S_BUSY = 2'd3;

  localparam int KEY_W_128 = 128;
  localparam int KEY_W_192 = 192;
  localparam int KEY_W_256 = 256;

  function automatic int words_of(input int width, input int bus);
    return width / bus;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aes_block_collector_if.sv
// Beat input bus between the host side and the AES block collector.
// Optional key_keep_i exists only when AES_KEY_REUSE_EN is defined.
interface aes_block_collector_if #(
  parameter int BUS_W = 32
);
  // Handshake: a beat transfers on a rising clk edge where in_valid_i and
  // in_ready_o are both high; text_i/key_i (and key_keep_i) must be held
  // stable while in_valid_i is high and in_ready_o is low.
  logic             in_valid_i;
  logic             in_ready_o;
  logic [BUS_W-1:0] text_i;
  logic [BUS_W-1:0] key_i;
`ifdef AES_KEY_REUSE_EN
  logic             key_keep_i;
`endif

  modport master (
`ifdef AES_KEY_REUSE_EN
    output key_keep_i,
`endif
    output in_valid_i,
    output text_i,
    output key_i,
    input  in_ready_o
  );

  modport slave (
`ifdef AES_KEY_REUSE_EN
    input  key_keep_i,
`endif
    input  in_valid_i,
    input  text_i,
    input  key_i,
    output in_ready_o
  );

endinterface

// File: rtl/aes_word_packer.sv
// Block register written one BUS_W word at a time at a selected word index.
// MSW_FIRST=1 maps word 0 to the most significant slot.
module aes_word_packer
  import aes_buf_pkg::*;
#(
  parameter int REG_W     = 128,
  parameter int BUS_W     = 32,
  parameter int MSW_FIRST = 0,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [BUS_W-1:0] word,
  output logic [REG_W-1:0] data
);

  localparam int N = words_of(REG_W, BUS_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (we) begin
      for (int k = 0; k < N; k++) begin
        if (idx == IDX_W'(k)) begin
          data[((MSW_FIRST != 0) ? (N - 1 - k) : k) * BUS_W +: BUS_W] <= word;
        end
      end
    end
  end

endmodule

// File: rtl/aes_block_collector.sv
// Gathers BUS_W beats into a text block and a 128/192/256-bit key, strobes ld_o
// and holds both blocks until done_i. Optional feature macro: AES_KEY_REUSE_EN.
module aes_block_collector
  import aes_buf_pkg::*;
#(
  parameter int BUS_W     = 32,
  parameter int TEXT_W    = 128,
  parameter int KEY_W     = 128,
  parameter int MSW_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_block_collector_if.slave bus,
  input  logic                 done_i,
  output logic [TEXT_W-1:0]    text_o,
  output logic [KEY_W-1:0]     key_o,
  output logic                 ld_o,
  output logic                 busy_o,
  output aes_state_t           dbg_state
);

  localparam int N_TXT   = words_of(TEXT_W, BUS_W);
  localparam int N_KEY   = words_of(KEY_W, BUS_W);
  localparam int N_BEATS = max_int(N_TXT, N_KEY);
  localparam int CNT_W   = $clog2(N_BEATS + 1);

  localparam logic [CNT_W-1:0] TXT_CNT  = CNT_W'(N_TXT);
  localparam logic [CNT_W-1:0] KEY_CNT  = CNT_W'(N_KEY);
  localparam logic [CNT_W-1:0] LAST_TXT = CNT_W'(N_TXT - 1);
  localparam logic [CNT_W-1:0] LAST_ALL = CNT_W'(N_BEATS - 1);

  if (KEY_W != KEY_W_128 && KEY_W != KEY_W_192 && KEY_W != KEY_W_256) begin : g_bad_key_w
    $error("aes_block_collector: KEY_W must be 128, 192 or 256");
  end
  if (TEXT_W % BUS_W != 0) begin : g_bad_text_w
    $error("aes_block_collector: TEXT_W must be a multiple of BUS_W");
  end
  if (KEY_W % BUS_W != 0) begin : g_bad_key_div
    $error("aes_block_collector: KEY_W must be a multiple of BUS_W");
  end

  aes_state_t       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] last_idx;
  logic             fire;
  logic             keep_blk;
  logic             text_we;
  logic             key_we;

  assign bus.in_ready_o = !rst && (state == S_IDLE || state == S_FILL);
  assign fire           = bus.in_valid_i && bus.in_ready_o;

`ifdef AES_KEY_REUSE_EN
  logic keep_q;

  // key_keep_i counts on the beat 0 fire; later beats use the latched copy.
  assign keep_blk = (state == S_IDLE) ? bus.key_keep_i : keep_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      keep_q <= 1'b0;
    end else if (fire && state == S_IDLE) begin
      keep_q <= bus.key_keep_i;
    end
  end
`else
  assign keep_blk = 1'b0;
`endif

  assign last_idx = keep_blk ? LAST_TXT : LAST_ALL;
  assign text_we  = fire && (beat_cnt < TXT_CNT);
  assign key_we   = fire && (beat_cnt < KEY_CNT) && !keep_blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_FILL: begin
          if (fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            state    <= (beat_cnt == last_idx) ? S_LOAD : S_FILL;
          end
        end
        S_LOAD: begin
          beat_cnt <= '0;
          state    <= S_BUSY;
        end
        S_BUSY: begin
          if (done_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ld_o      = (state == S_LOAD);
  assign busy_o    = (state == S_BUSY);
  assign dbg_state = state;

  aes_word_packer #(
    .REG_W     (TEXT_W),
    .BUS_W     (BUS_W),
    .MSW_FIRST (MSW_FIRST),
    .IDX_W     (CNT_W)
  ) u_text_packer (
    .clk  (clk),
    .rst  (rst),
    .we   (text_we),
    .idx  (beat_cnt),
    .word (bus.text_i),
    .data (text_o)
  );

  aes_word_packer #(
    .REG_W     (KEY_W),
    .BUS_W     (BUS_W),
    .MSW_FIRST (MSW_FIRST),
    .IDX_W     (CNT_W)
  ) u_key_packer (
    .clk  (clk),
    .rst  (rst),
    .we   (key_we),
    .idx  (beat_cnt),
    .word (bus.key_i),
    .data (key_o)
  );

endmodule
